set_bit_walker: RTL and testbench

- Downstream stage of the highest-set-bit encoder. Takes one N-bit word and emits the index of every set bit, highest first, one index per beat.
- Both sides use valid/ready handshakes.
- Used wherever a one-hot/multi-hot request word must be serviced bit by bit: interrupt vectors, request masks, sparse flags.

---
 rtl/set_bit_walker.sv | 97 +++++++++
 tb/tb_set_bit_walker.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/set_bit_walker.sv
// Purpose: walks an accepted N-bit word and emits each set-bit index, highest first, one per beat.
// Latency: first beat appears one cycle after accept; back-to-back words sustain one beat per cycle.
// Backpressure: beats hold stable while out_ready=0; a new word is only taken with the final beat.
// Optional build macro SET_BIT_WALKER_CNT_EN adds out_cnt, the popcount of the accepted word.
module set_bit_walker #(
    parameter int N = 8,
    localparam int PW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_pos,
    output logic          out_last,
    output logic          out_zero
`ifdef SET_BIT_WALKER_CNT_EN
    ,
    output logic [$clog2(N+1)-1:0] out_cnt
`endif
);

    typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

    state_t         state;
    logic [N-1:0]   work;
    logic           zero_flag;
    logic [PW-1:0]  pos_c;
    logic           accept;
    logic           beat;

    // Priority scan: ascending loop so the highest set index is the final assignment.
    always_comb begin
        pos_c = '0;
        for (int i = 0; i < N; i++) begin
            if (work[i]) begin
                pos_c = PW'(i);
            end
        end
    end

    // Outputs depend only on registered state; rst masks valid so no beat leaks during reset.
    assign out_valid = (state == EMIT) && !rst;
    assign out_pos   = pos_c;
    assign out_last  = ((work & (work - N'(1))) == '0);
    assign out_zero  = zero_flag;

    // A new word may load in the same cycle the final beat of the previous one is taken.
    assign in_ready = !rst && ((state == IDLE) || ((state == EMIT) && out_last && out_ready));
    assign accept   = in_valid && in_ready;
    assign beat     = out_valid && out_ready;

`ifdef SET_BIT_WALKER_CNT_EN
    localparam int CW = $clog2(N+1);
    logic [CW-1:0] cnt_c;
    logic [CW-1:0] cnt_q;

    // Population count of the incoming word, captured only at accept.
    always_comb begin
        cnt_c = '0;
        for (int i = 0; i < N; i++) begin
            cnt_c = cnt_c + CW'(in_data[i]);
        end
    end

    assign out_cnt = cnt_q;
`endif

    // Walker state: load on accept, otherwise retire the emitted bit on each taken beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            work      <= '0;
            zero_flag <= 1'b0;
`ifdef SET_BIT_WALKER_CNT_EN
            cnt_q     <= '0;
`endif
        end else if (accept) begin
            state     <= EMIT;
            work      <= in_data;
            zero_flag <= (in_data == '0);
`ifdef SET_BIT_WALKER_CNT_EN
            cnt_q     <= cnt_c;
`endif
        end else if (beat) begin
            if (out_last) begin
                state <= IDLE;
                work  <= '0;
            end else begin
                work <= work & ~(N'(1) << pos_c);
            end
        end
    end

endmodule

// File: tb/tb_set_bit_walker.sv
module tb_set_bit_walker;

    typedef struct {
        int pos;
        bit last;
        bit zero;
        int cnt;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [2:0]  out_pos;
    logic        out_last;
    logic        out_zero;
`ifdef SET_BIT_WALKER_CNT_EN
    logic [3:0]  out_cnt;
`endif

    logic        iv64 = 1'b0;
    logic        ir64;
    logic [63:0] id64 = '0;
    logic        ov64;
    logic [5:0]  op64;
    logic        ol64;
    logic        oz64;
`ifdef SET_BIT_WALKER_CNT_EN
    logic [6:0]  oc64;
`endif

    int    nchecks = 0;
    int    nerrors = 0;
    int    rmode   = 0;
    beat_t q[$];
    beat_t q64[$];

    always #5 clk = ~clk;

    set_bit_walker #(.N(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pos(out_pos), .out_last(out_last), .out_zero(out_zero)
`ifdef SET_BIT_WALKER_CNT_EN
        , .out_cnt(out_cnt)
`endif
    );

    set_bit_walker #(.N(64)) dut64 (
        .clk(clk), .rst(rst),
        .in_valid(iv64), .in_ready(ir64), .in_data(id64),
        .out_valid(ov64), .out_ready(1'b1),
        .out_pos(op64), .out_last(ol64), .out_zero(oz64)
`ifdef SET_BIT_WALKER_CNT_EN
        , .out_cnt(oc64)
`endif
    );

    function automatic void check(input string name, input longint act, input longint exp);
        nchecks++;
        if (act != exp) begin
            nerrors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference: list the set bits of the word from the top down; a zero word is one flagged beat.
    function automatic void model_push8(input logic [7:0] w);
        int k = $countones(w);
        int seen = 0;
        if (w == '0) q.push_back('{pos: 0, last: 1'b1, zero: 1'b1, cnt: 0});
        for (int i = 7; i >= 0; i--) begin
            if (w[i]) begin
                seen++;
                q.push_back('{pos: i, last: (seen == k), zero: 1'b0, cnt: k});
            end
        end
    endfunction

    function automatic void model_push64(input logic [63:0] w);
        int k = $countones(w);
        int seen = 0;
        if (w == '0) q64.push_back('{pos: 0, last: 1'b1, zero: 1'b1, cnt: 0});
        for (int i = 63; i >= 0; i--) begin
            if (w[i]) begin
                seen++;
                q64.push_back('{pos: i, last: (seen == k), zero: 1'b0, cnt: k});
            end
        end
    endfunction

    // Consumer readiness pattern, changed just after each rising edge.
    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Scoreboard monitor for the N=8 instance: compares every presented beat, pops on handshake.
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            check("rst_out_valid", out_valid, 0);
            check("rst_in_ready", in_ready, 0);
            q.delete();
        end else begin
            check("out_valid_vs_model", out_valid, (q.size() != 0));
            check("in_ready_vs_model", in_ready, (q.size() == 0) || (q.size() == 1 && out_ready));
            if (out_valid && q.size() != 0) begin
                e = q[0];
                check("out_pos", out_pos, e.pos);
                check("out_last", out_last, e.last);
                check("out_zero", out_zero, e.zero);
`ifdef SET_BIT_WALKER_CNT_EN
                check("out_cnt", out_cnt, e.cnt);
`endif
                if (out_ready) void'(q.pop_front());
            end
            if (in_valid && in_ready) model_push8(in_data);
        end
    end

    // Scoreboard monitor for the N=64 instance (always ready consumer).
    always @(negedge clk) begin
        beat_t e;
        if (!rst) begin
            check("w64_out_valid", ov64, (q64.size() != 0));
            if (ov64 && q64.size() != 0) begin
                e = q64.pop_front();
                check("w64_out_pos", op64, e.pos);
                check("w64_out_last", ol64, e.last);
                check("w64_out_zero", oz64, e.zero);
`ifdef SET_BIT_WALKER_CNT_EN
                check("w64_out_cnt", oc64, e.cnt);
`endif
            end
            if (iv64 && ir64) model_push64(id64);
        end
    end

    task automatic send(input logic [7:0] w);
        int t = 0;
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic send64(input logic [63:0] w);
        int t = 0;
        iv64 = 1'b1;
        id64 = w;
        @(negedge clk);
        while (!ir64 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!ir64) check("send64_timeout", 0, 1);
        @(posedge clk);
        #1;
        iv64 = 1'b0;
        id64 = {$urandom, $urandom};
    endtask

    task automatic drain();
        int t = 0;
        while ((q.size() != 0 || q64.size() != 0) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0 || q64.size() != 0) check("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] w;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_out_pos", out_pos, 0);
        check("reset_out_last", out_last, 1);
        check("reset_out_zero", out_zero, 0);
        @(posedge clk);
        #1;

        // Two set bits, zero word, all ones under toggling backpressure.
        send(8'b0010_0100);
        drain();
        send(8'h00);
        drain();
        rmode = 1;
        send(8'hFF);
        drain();
        rmode = 0;

        // Back-to-back words with no idle cycle between them.
        send(8'h81);
        send(8'h10);
        drain();

        // Reset after the first beat of a walk discards the rest.
        send(8'hF0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Wide instance: top bit, top and bottom bits, a random word.
        send64(64'h8000_0000_0000_0000);
        send64(64'h8000_0000_0000_0001);
        send64({$urandom, $urandom});
        drain();

        // Random words, random gaps, random consumer stalls.
        rmode = 2;
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0:       w = 8'h00;
                1:       w = 8'($urandom) & 8'($urandom);
                default: w = 8'($urandom);
            endcase
            send(w);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        rmode = 0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
